// File: rtl/seq_det_pkg.sv
// Shared limits, helpers and default pattern for the N-symbol sequence detector.
// Optional match counter is enabled by defining SEQ_DET_COUNT_EN.
package seq_det_pkg;

  localparam int SYM_W_MIN = 1;
  localparam int SYM_W_MAX = 8;
  localparam int LEN_MIN   = 2;
  localparam int LEN_MAX   = 8;

  localparam int DEF_SYM_W = 2;
  localparam int DEF_LEN   = 3;

  localparam logic [DEF_LEN*DEF_SYM_W-1:0] PAT_DEFAULT =
    {2'd1, 2'd2, 2'd3};

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/seq_hist_shift.sv
// Symbol history shift register with a saturating fill count.
// Newest symbol sits in the least-significant field.
module seq_hist_shift
  import seq_det_pkg::*;
#(
  parameter int  SYM_W = 2,
  parameter int  LEN   = 3,
  localparam int FW    = clog2(LEN + 1),
  localparam int HW    = LEN * SYM_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift,
  input  logic             flush,
  input  logic [SYM_W-1:0] din,
  output logic [HW-1:0]    hist,
  output logic [FW-1:0]    fill,
  output logic [HW-1:0]    hist_nx,
  output logic [FW-1:0]    fill_nx
);

  localparam logic [FW-1:0] FULL = FW'(LEN);

  logic [HW-1:0] hist_q, hist_d;
  logic [FW-1:0] fill_q, fill_d;

  // Post-shift view, used by the parent to detect a match on this edge
  assign hist_nx = {hist_q[HW-SYM_W-1:0], din};
  assign fill_nx = (fill_q == FULL) ? FULL : fill_q + 1'b1;

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (shift) begin
      hist_d = hist_nx;
      fill_d = fill_nx;
    end
    if (flush) fill_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  assign hist = hist_q;
  assign fill = fill_q;

endmodule

// File: rtl/seq_detector_n.sv
// Programmable N-symbol sequence detector with sticky/pulse and overlap modes.
// Define SEQ_DET_COUNT_EN to add the saturating match_cnt port and counter.
module seq_detector_n
  import seq_det_pkg::*;
#(
  parameter int                   SYM_W   = 2,
  parameter int                   LEN     = 3,
  parameter logic [LEN*SYM_W-1:0] PAT_RST = PAT_DEFAULT,
  parameter bit                   STICKY  = 1'b1,
  parameter bit                   OVERLAP = 1'b1,
  parameter int                   CNT_W   = 8,
  localparam int                  PW      = clog2(LEN + 1),
  localparam int                  HW      = LEN * SYM_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SYM_W-1:0] num,
  input  logic             in_valid,
  input  logic             clear,
  input  logic             cfg_we,
  input  logic [HW-1:0]    cfg_pattern,
  output logic             ans,
  output logic [PW-1:0]    progress
`ifdef SEQ_DET_COUNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  localparam logic [PW-1:0] FULL = PW'(LEN);

  logic [HW-1:0] pat_q, pat_d;
  logic          ans_q, ans_d;
  logic [HW-1:0] hist, hist_nx;
  logic [PW-1:0] fill, fill_nx;
  logic          shift, flush, match, restart;
  logic [PW-1:0] prog;
  logic          ok;

  // cfg_we and clear both swallow any symbol presented with them
  assign shift   = in_valid & ~cfg_we & ~clear;
  assign match   = shift & (fill_nx == FULL) & (hist_nx == pat_q);
  assign restart = OVERLAP ? 1'b0 : match;
  assign flush   = cfg_we | clear | restart;

  seq_hist_shift #(
    .SYM_W(SYM_W),
    .LEN  (LEN)
  ) u_hist (
    .clk    (clk),
    .reset  (reset),
    .shift  (shift),
    .flush  (flush),
    .din    (num),
    .hist   (hist),
    .fill   (fill),
    .hist_nx(hist_nx),
    .fill_nx(fill_nx)
  );

  always_comb begin
    pat_d = cfg_we ? cfg_pattern : pat_q;
    if (cfg_we | clear) ans_d = 1'b0;
    else if (STICKY)    ans_d = ans_q | match;
    else                ans_d = match;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q <= PAT_RST;
      ans_q <= 1'b0;
    end else begin
      pat_q <= pat_d;
      ans_q <= ans_d;
    end
  end

  // Longest pattern prefix equal to the newest k accepted symbols
  always_comb begin
    prog = '0;
    ok   = 1'b0;
    for (int k = 1; k <= LEN; k++) begin
      ok = (int'(fill) >= k);
      for (int j = 0; j < k; j++) begin
        if (hist[(k-1-j)*SYM_W +: SYM_W] !=
            pat_q[(LEN-1-j)*SYM_W +: SYM_W])
          ok = 1'b0;
      end
      if (ok) prog = PW'(k);
    end
  end

  assign ans      = ans_q;
  assign progress = prog;

`ifdef SEQ_DET_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cfg_we | clear)                cnt_d = '0;
    else if (match && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign match_cnt = cnt_q;
`endif

endmodule
